// File: rtl/crdhold_stream_arbiter.sv
// crdhold_stream_arbiter
//   Shares one crdhold unit between two requesters. A requester owns the
//   unit for a whole job, from its first token until the done token has
//   left the unit on both output streams. While it owns the unit, its two
//   input streams and two output streams are muxed straight onto the
//   cmrg_* ports with no added latency. Token data is never modified.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   clk_en, tile_en            both must be 1 for state to advance;
//                              otherwise all valid/ready outputs are 0
//   flush                      synchronous soft reset of arbitration state
//   rR_coord_in_K[_valid]      requester R input stream K (into the arbiter)
//   rR_coord_in_K_ready        ready back to requester R
//   rR_coord_out_K[_valid]     requester R output stream K (out of arbiter)
//   rR_coord_out_K_ready       ready from requester R sink
//   cmrg_coord_in_K[_valid]    stream K towards the shared unit
//   cmrg_coord_in_K_ready      ready from the shared unit
//   cmrg_coord_out_K[_valid]   stream K coming back from the shared unit
//   cmrg_coord_out_K_ready     ready towards the shared unit
//   grant                      one-hot owner, 0 when idle
//   busy                       1 while a job is granted
//
// Optional feature (macro CRDHOLD_ARB_STATS_EN)
//   Adds r0_jobs_done / r1_jobs_done: 16-bit wrapping per-requester
//   counts of completed jobs, cleared by reset and flush.

module crdhold_stream_arbiter #(
  parameter int                    DATA_WIDTH = 17,
  parameter logic [DATA_WIDTH-1:0] DONE_TOKEN = 17'h10100
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_en,
  input  logic                  flush,
  input  logic                  tile_en,

  input  logic [DATA_WIDTH-1:0] r0_coord_in_0,
  input  logic                  r0_coord_in_0_valid,
  output logic                  r0_coord_in_0_ready,
  input  logic [DATA_WIDTH-1:0] r0_coord_in_1,
  input  logic                  r0_coord_in_1_valid,
  output logic                  r0_coord_in_1_ready,
  output logic [DATA_WIDTH-1:0] r0_coord_out_0,
  output logic                  r0_coord_out_0_valid,
  input  logic                  r0_coord_out_0_ready,
  output logic [DATA_WIDTH-1:0] r0_coord_out_1,
  output logic                  r0_coord_out_1_valid,
  input  logic                  r0_coord_out_1_ready,

  input  logic [DATA_WIDTH-1:0] r1_coord_in_0,
  input  logic                  r1_coord_in_0_valid,
  output logic                  r1_coord_in_0_ready,
  input  logic [DATA_WIDTH-1:0] r1_coord_in_1,
  input  logic                  r1_coord_in_1_valid,
  output logic                  r1_coord_in_1_ready,
  output logic [DATA_WIDTH-1:0] r1_coord_out_0,
  output logic                  r1_coord_out_0_valid,
  input  logic                  r1_coord_out_0_ready,
  output logic [DATA_WIDTH-1:0] r1_coord_out_1,
  output logic                  r1_coord_out_1_valid,
  input  logic                  r1_coord_out_1_ready,

  output logic [DATA_WIDTH-1:0] cmrg_coord_in_0,
  output logic                  cmrg_coord_in_0_valid,
  input  logic                  cmrg_coord_in_0_ready,
  output logic [DATA_WIDTH-1:0] cmrg_coord_in_1,
  output logic                  cmrg_coord_in_1_valid,
  input  logic                  cmrg_coord_in_1_ready,
  input  logic [DATA_WIDTH-1:0] cmrg_coord_out_0,
  input  logic                  cmrg_coord_out_0_valid,
  output logic                  cmrg_coord_out_0_ready,
  input  logic [DATA_WIDTH-1:0] cmrg_coord_out_1,
  input  logic                  cmrg_coord_out_1_valid,
  output logic                  cmrg_coord_out_1_ready,

  output logic [1:0]            grant,
  output logic                  busy
`ifdef CRDHOLD_ARB_STATS_EN
  ,
  output logic [15:0]           r0_jobs_done,
  output logic [15:0]           r1_jobs_done
`endif
);

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_owner_q, last_owner_d;
  logic [1:0] in_done_q, in_done_d;
  logic [1:0] out_done_q, out_done_d;
  logic       release_job;
  logic       active;
  logic [1:0] req_any;

  // Port bundles indexed [requester][stream] so the mux is a plain index.
  data_t req_in_data   [2][2];
  logic  req_in_valid  [2][2];
  logic  req_out_ready [2][2];
  data_t unit_out_data [2];
  logic  unit_out_valid[2];
  logic  unit_in_ready [2];

  logic  req_in_ready_c [2][2];
  logic  req_out_valid_c[2][2];
  data_t req_out_data_c [2][2];
  data_t unit_in_data_c [2];
  logic  unit_in_valid_c[2];
  logic  unit_out_ready_c[2];

  assign req_in_data[0][0]   = r0_coord_in_0;
  assign req_in_data[0][1]   = r0_coord_in_1;
  assign req_in_data[1][0]   = r1_coord_in_0;
  assign req_in_data[1][1]   = r1_coord_in_1;
  assign req_in_valid[0][0]  = r0_coord_in_0_valid;
  assign req_in_valid[0][1]  = r0_coord_in_1_valid;
  assign req_in_valid[1][0]  = r1_coord_in_0_valid;
  assign req_in_valid[1][1]  = r1_coord_in_1_valid;
  assign req_out_ready[0][0] = r0_coord_out_0_ready;
  assign req_out_ready[0][1] = r0_coord_out_1_ready;
  assign req_out_ready[1][0] = r1_coord_out_0_ready;
  assign req_out_ready[1][1] = r1_coord_out_1_ready;
  assign unit_out_data[0]    = cmrg_coord_out_0;
  assign unit_out_data[1]    = cmrg_coord_out_1;
  assign unit_out_valid[0]   = cmrg_coord_out_0_valid;
  assign unit_out_valid[1]   = cmrg_coord_out_1_valid;
  assign unit_in_ready[0]    = cmrg_coord_in_0_ready;
  assign unit_in_ready[1]    = cmrg_coord_in_1_ready;

  // tile_en=0 behaves exactly like a clock-enable stall.
  assign active     = clk_en & tile_en;
  assign req_any[0] = req_in_valid[0][0] | req_in_valid[0][1];
  assign req_any[1] = req_in_valid[1][0] | req_in_valid[1][1];

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the block leaves a value unassigned and no latch is inferred.
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 2; k++) begin
        req_in_ready_c[r][k]  = 1'b0;
        req_out_valid_c[r][k] = 1'b0;
        req_out_data_c[r][k]  = '0;
      end
    end
    for (int k = 0; k < 2; k++) begin
      unit_in_data_c[k]   = '0;
      unit_in_valid_c[k]  = 1'b0;
      unit_out_ready_c[k] = 1'b0;
    end

    // Data follows the owner even while stalled, so it holds steady as long
    // as the upstream holds; only the handshakes are suppressed on a stall.
    if (state_q == GRANT) begin
      for (int k = 0; k < 2; k++) begin
        unit_in_data_c[k]          = req_in_data[owner_q][k];
        req_out_data_c[owner_q][k] = unit_out_data[k];
        if (active) begin
          // A stream whose done token has gone in stays closed so the
          // owner's next job cannot leak into the current one.
          unit_in_valid_c[k]          = req_in_valid[owner_q][k] & ~in_done_q[k];
          req_in_ready_c[owner_q][k]  = unit_in_ready[k] & ~in_done_q[k];
          req_out_valid_c[owner_q][k] = unit_out_valid[k];
          unit_out_ready_c[k]         = req_out_ready[owner_q][k];
        end
      end
    end

    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    in_done_d    = in_done_q;
    out_done_d   = out_done_q;
    release_job  = 1'b0;

    for (int k = 0; k < 2; k++) begin
      if (unit_in_valid_c[k] && unit_in_ready[k] && unit_in_data_c[k] == DONE_TOKEN)
        in_done_d[k] = 1'b1;
      if (unit_out_valid[k] && unit_out_ready_c[k] && unit_out_data[k] == DONE_TOKEN)
        out_done_d[k] = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (active && (req_any[0] || req_any[1])) begin
          state_d = GRANT;
          owner_d = (req_any[0] && req_any[1]) ? ~last_owner_q : req_any[1];
        end
      end
      GRANT: begin
        // Release looks at the flags including this cycle's transfers, so
        // the final done token and the release happen on the same edge.
        if (&out_done_d) begin
          state_d      = IDLE;
          last_owner_d = owner_q;
          in_done_d    = '0;
          out_done_d   = '0;
          release_job  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef CRDHOLD_ARB_STATS_EN
  logic [15:0] jobs_q[2];
  assign r0_jobs_done = jobs_q[0];
  assign r1_jobs_done = jobs_q[1];
`endif

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    if (!rst_n || flush) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      in_done_q    <= '0;
      out_done_q   <= '0;
`ifdef CRDHOLD_ARB_STATS_EN
      jobs_q[0]    <= '0;
      jobs_q[1]    <= '0;
`endif
    end else if (active) begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      in_done_q    <= in_done_d;
      out_done_q   <= out_done_d;
`ifdef CRDHOLD_ARB_STATS_EN
      if (release_job) jobs_q[owner_q] <= jobs_q[owner_q] + 16'd1;
`endif
    end
  end

  assign r0_coord_in_0_ready    = req_in_ready_c[0][0];
  assign r0_coord_in_1_ready    = req_in_ready_c[0][1];
  assign r1_coord_in_0_ready    = req_in_ready_c[1][0];
  assign r1_coord_in_1_ready    = req_in_ready_c[1][1];
  assign r0_coord_out_0         = req_out_data_c[0][0];
  assign r0_coord_out_1         = req_out_data_c[0][1];
  assign r1_coord_out_0         = req_out_data_c[1][0];
  assign r1_coord_out_1         = req_out_data_c[1][1];
  assign r0_coord_out_0_valid   = req_out_valid_c[0][0];
  assign r0_coord_out_1_valid   = req_out_valid_c[0][1];
  assign r1_coord_out_0_valid   = req_out_valid_c[1][0];
  assign r1_coord_out_1_valid   = req_out_valid_c[1][1];
  assign cmrg_coord_in_0        = unit_in_data_c[0];
  assign cmrg_coord_in_1        = unit_in_data_c[1];
  assign cmrg_coord_in_0_valid  = unit_in_valid_c[0];
  assign cmrg_coord_in_1_valid  = unit_in_valid_c[1];
  assign cmrg_coord_out_0_ready = unit_out_ready_c[0];
  assign cmrg_coord_out_1_ready = unit_out_ready_c[1];

  assign busy  = (state_q == GRANT);
  assign grant = busy ? (owner_q ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_crdhold_stream_arbiter.sv
// Testbench for crdhold_stream_arbiter.
//   A driver process plays both requesters' sources and sinks plus a FIFO
//   model of the shared unit. Stimulus pushes each token into a source queue
//   and its expected arrival into a scoreboard queue; a monitor pops and
//   compares on every requester output transfer and checks the ownership
//   and done-gating rules every cycle. Inputs change on the falling edge,
//   handshakes are sampled 1 time unit before the rising edge.

module tb_crdhold_stream_arbiter;

  localparam logic [16:0] DONE = 17'h10100;

  logic clk = 1'b0;
  logic rst_n, clk_en, flush, tile_en;
  always #5 clk = ~clk;

  logic [16:0] rin_d [2][2];
  logic        rin_v [2][2];
  logic        rin_r [2][2];
  logic [16:0] rout_d[2][2];
  logic        rout_v[2][2];
  logic        rout_r[2][2];
  logic [16:0] cin_d [2];
  logic        cin_v [2];
  logic        cin_r [2];
  logic [16:0] cout_d[2];
  logic        cout_v[2];
  logic        cout_r[2];
  logic [1:0]  grant;
  logic        busy;
`ifdef CRDHOLD_ARB_STATS_EN
  logic [15:0] r0_jobs, r1_jobs;
`endif

  int   vectors = 0;
  int   miscompares = 0;
  logic rnd_mode = 1'b0;

  logic [16:0] src_q [2][2][$];
  logic [16:0] exp_q [2][2][$];
  logic [16:0] unit_q[2][$];

  crdhold_stream_arbiter dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush), .tile_en(tile_en),
    .r0_coord_in_0(rin_d[0][0]), .r0_coord_in_0_valid(rin_v[0][0]), .r0_coord_in_0_ready(rin_r[0][0]),
    .r0_coord_in_1(rin_d[0][1]), .r0_coord_in_1_valid(rin_v[0][1]), .r0_coord_in_1_ready(rin_r[0][1]),
    .r0_coord_out_0(rout_d[0][0]), .r0_coord_out_0_valid(rout_v[0][0]), .r0_coord_out_0_ready(rout_r[0][0]),
    .r0_coord_out_1(rout_d[0][1]), .r0_coord_out_1_valid(rout_v[0][1]), .r0_coord_out_1_ready(rout_r[0][1]),
    .r1_coord_in_0(rin_d[1][0]), .r1_coord_in_0_valid(rin_v[1][0]), .r1_coord_in_0_ready(rin_r[1][0]),
    .r1_coord_in_1(rin_d[1][1]), .r1_coord_in_1_valid(rin_v[1][1]), .r1_coord_in_1_ready(rin_r[1][1]),
    .r1_coord_out_0(rout_d[1][0]), .r1_coord_out_0_valid(rout_v[1][0]), .r1_coord_out_0_ready(rout_r[1][0]),
    .r1_coord_out_1(rout_d[1][1]), .r1_coord_out_1_valid(rout_v[1][1]), .r1_coord_out_1_ready(rout_r[1][1]),
    .cmrg_coord_in_0(cin_d[0]), .cmrg_coord_in_0_valid(cin_v[0]), .cmrg_coord_in_0_ready(cin_r[0]),
    .cmrg_coord_in_1(cin_d[1]), .cmrg_coord_in_1_valid(cin_v[1]), .cmrg_coord_in_1_ready(cin_r[1]),
    .cmrg_coord_out_0(cout_d[0]), .cmrg_coord_out_0_valid(cout_v[0]), .cmrg_coord_out_0_ready(cout_r[0]),
    .cmrg_coord_out_1(cout_d[1]), .cmrg_coord_out_1_valid(cout_v[1]), .cmrg_coord_out_1_ready(cout_r[1]),
    .grant(grant), .busy(busy)
`ifdef CRDHOLD_ARB_STATS_EN
    , .r0_jobs_done(r0_jobs), .r1_jobs_done(r1_jobs)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic any_handshake();
    logic a = 1'b0;
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 2; k++) a |= rin_r[r][k] | rout_v[r][k];
    for (int k = 0; k < 2; k++) a |= cin_v[k] | cout_r[k];
    return a;
  endfunction

  function automatic logic any_data();
    logic a = 1'b0;
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 2; k++) a |= |rout_d[r][k];
    for (int k = 0; k < 2; k++) a |= |cin_d[k];
    return a;
  endfunction

  function automatic logic all_empty();
    logic e = 1'b1;
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 2; k++)
        if (src_q[r][k].size() != 0 || exp_q[r][k].size() != 0) e = 1'b0;
    for (int k = 0; k < 2; k++)
      if (unit_q[k].size() != 0) e = 1'b0;
    return e;
  endfunction

  // Environment: requester sources/sinks and a per-stream FIFO unit model.
  initial begin
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 2; k++) begin
        rin_v[r][k] = 1'b0; rin_d[r][k] = '0; rout_r[r][k] = 1'b0;
      end
    for (int k = 0; k < 2; k++) begin
      cin_r[k] = 1'b0; cout_v[k] = 1'b0; cout_d[k] = '0;
    end
    forever begin
      @(negedge clk);
      if (flush) begin
        for (int r = 0; r < 2; r++)
          for (int k = 0; k < 2; k++) begin
            src_q[r][k].delete(); exp_q[r][k].delete();
          end
        for (int k = 0; k < 2; k++) unit_q[k].delete();
      end
      for (int r = 0; r < 2; r++)
        for (int k = 0; k < 2; k++) begin
          rin_v[r][k]  = (src_q[r][k].size() != 0);
          rin_d[r][k]  = rin_v[r][k] ? src_q[r][k][0] : 17'h0;
          rout_r[r][k] = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
      for (int k = 0; k < 2; k++) begin
        cin_r[k]  = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        cout_v[k] = (unit_q[k].size() != 0);
        cout_d[k] = cout_v[k] ? unit_q[k][0] : 17'h0;
      end
      #4;
      for (int r = 0; r < 2; r++)
        for (int k = 0; k < 2; k++)
          if (rin_v[r][k] && rin_r[r][k]) void'(src_q[r][k].pop_front());
      for (int k = 0; k < 2; k++) begin
        if (cout_v[k] && cout_r[k]) void'(unit_q[k].pop_front());
        if (cin_v[k] && cin_r[k]) unit_q[k].push_back(cin_d[k]);
      end
    end
  end

  // Monitor: scoreboard compare plus per-cycle ownership rules.
  initial begin
    logic [1:0]  idone, odone;
    logic        exp_idle;
    logic [16:0] e;
    int          ow;
    idone = '0; odone = '0; exp_idle = 1'b0;
    forever begin
      @(negedge clk);
      #4;
      if (flush || !rst_n) begin
        idone = '0; odone = '0; exp_idle = 1'b0;
        continue;
      end
      if (exp_idle) begin
        check("release_idle", 32'({grant, busy}), 32'd0);
        exp_idle = 1'b0;
      end
      if (grant == 2'b01 || grant == 2'b10) begin
        ow = grant[1] ? 1 : 0;
        for (int k = 0; k < 2; k++) begin
          if (idone[k]) check($sformatf("done_gate_r%0d_in%0d", ow, k), 32'(rin_r[ow][k]), 32'd0);
          check($sformatf("nonowner_quiet_r%0d_%0d", 1 - ow, k),
                32'({rin_r[1-ow][k], rout_v[1-ow][k]}), 32'd0);
        end
      end
      for (int r = 0; r < 2; r++)
        for (int k = 0; k < 2; k++)
          if (rout_v[r][k] && rout_r[r][k]) begin
            if (exp_q[r][k].size() == 0) begin
              vectors++;
              miscompares++;
              $display("FAIL r%0d_out%0d: got unexpected token %h, expected none", r, k, rout_d[r][k]);
            end else begin
              e = exp_q[r][k].pop_front();
              check($sformatf("r%0d_out%0d_token", r, k), 32'(rout_d[r][k]), 32'(e));
              if (e == DONE) odone[k] = 1'b1;
            end
          end
      for (int r = 0; r < 2; r++)
        for (int k = 0; k < 2; k++)
          if (rin_v[r][k] && rin_r[r][k] && rin_d[r][k] == DONE) idone[k] = 1'b1;
      if (&odone) begin
        exp_idle = 1'b1; idone = '0; odone = '0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int r, input int k, input logic [16:0] t);
    src_q[r][k].push_back(t);
    exp_q[r][k].push_back(t);
  endtask

  task automatic send_job(input int r, input logic [16:0] a, input logic [16:0] b);
    send(r, 0, a); send(r, 0, DONE);
    send(r, 1, b); send(r, 1, DONE);
  endtask

  task automatic wait_grant(input logic [1:0] g, input string name);
    int n = 0;
    while (grant !== g && n < 200) begin tick(); n++; end
    check(name, 32'(grant), 32'(g));
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (!(all_empty() && !busy) && n < 1000) begin tick(); n++; end
    check(name, 32'(all_empty() && !busy), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [1:0] g;
    rst_n = 1'b0; clk_en = 1'b1; flush = 1'b0; tile_en = 1'b1;
    do_reset();
    check("reset_grant_busy", 32'({grant, busy}), 32'd0);
    check("reset_handshakes", 32'(any_handshake()), 32'd0);
    check("reset_data", 32'(any_data()), 32'd0);

    // T1: single r0 job, grant one cycle after the first valid.
    send(0, 0, 17'h00002); send(0, 0, 17'h00005); send(0, 0, DONE);
    send(0, 1, 17'h00002); send(0, 1, 17'h00005); send(0, 1, DONE);
    tick();
    check("t1_grant", 32'(grant), 32'd1);
    wait_drain("t1_drain");
`ifdef CRDHOLD_ARB_STATS_EN
    check("t1_r0_jobs", 32'(r0_jobs), 32'd1);
`endif

    // T3: round robin after an r0 job -> r1 first.
    send_job(0, 17'h0000a, 17'h0001a);
    send_job(1, 17'h0000b, 17'h0001b);
    tick();
    check("t3_grant_r1", 32'(grant), 32'd2);
    wait_grant(2'b01, "t3_grant_r0_next");
    wait_drain("t3_drain");

    // T2: simultaneous request straight after reset -> r0 first.
    do_reset();
`ifdef CRDHOLD_ARB_STATS_EN
    check("t2_reset_jobs", 32'({r0_jobs, r1_jobs}), 32'd0);
`endif
    send_job(0, 17'h00012, 17'h00022);
    send_job(1, 17'h00013, 17'h00023);
    tick();
    check("t2_grant_r0", 32'(grant), 32'd1);
    wait_grant(2'b10, "t2_grant_r1_next");
    wait_drain("t2_drain");

    // T4: r0 queues its next job right behind each done token.
    send(0, 0, 17'h00021); send(0, 0, DONE); send(0, 0, 17'h00022); send(0, 0, DONE);
    send(0, 1, 17'h00031); send(0, 1, DONE); send(0, 1, 17'h00032); send(0, 1, DONE);
    tick();
    check("t4_grant", 32'(grant), 32'd1);
    wait_drain("t4_drain");

    // T5: flush during an unfinished r1 job with in_done[0] already set.
    send(1, 0, 17'h00041); send(1, 0, DONE);
    for (int i = 0; i < 6; i++) send(1, 1, 17'(17'h00051 + i));
    wait_grant(2'b10, "t5_grant_r1");
    repeat (4) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t5_flush_idle", 32'({grant, busy}), 32'd0);
`ifdef CRDHOLD_ARB_STATS_EN
    check("t5_flush_jobs", 32'({r0_jobs, r1_jobs}), 32'd0);
`endif
    send_job(0, 17'h00061, 17'h00062);
    send_job(1, 17'h00071, 17'h00072);
    tick();
    check("t5_grant_r0_after_flush", 32'(grant), 32'd1);
    wait_drain("t5_drain");
`ifdef CRDHOLD_ARB_STATS_EN
    check("t5_jobs", 32'({r0_jobs, r1_jobs}), 32'h00010001);
`endif

    // T6: random backpressure with a 5-cycle clk_en stall mid-job.
    rnd_mode = 1'b1;
    for (int i = 0; i < 6; i++) send(0, 0, 17'(17'h00081 + i));
    send(0, 0, DONE);
    for (int i = 0; i < 5; i++) send(0, 1, 17'(17'h00091 + i));
    send(0, 1, DONE);
    send_job(1, 17'h000a1, 17'h000b1);
    tick();
    check("t6_grant", 32'(grant), 32'd1);
    repeat (3) tick();
    g = grant;
    clk_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t6_stall_grant", 32'(grant), 32'(g));
      check("t6_stall_handshakes", 32'(any_handshake()), 32'd0);
    end
    clk_en = 1'b1;
    wait_drain("t6_drain");
    rnd_mode = 1'b0;

    // tile_en=0 keeps an idle block idle despite a request.
    tile_en = 1'b0;
    send_job(0, 17'h000c1, 17'h000c2);
    repeat (3) tick();
    check("tile_off_idle", 32'({grant, busy}), 32'd0);
    tile_en = 1'b1;
    tick();
    check("tile_on_grant", 32'(grant), 32'd1);
    wait_drain("tile_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

endmodule
